// File: rtl/dino_runner_core.sv
// dino_runner_core: dino game FSM, jump physics, NUM_OBS scrolling obstacles, collision, score/speed ramp and pixel renderer; define HISCORE_EN to add the hiscore port
module dino_runner_core #(
  parameter int NUM_OBS    = 3,
  parameter int SCORE_W    = 16,
  parameter int SIZE       = 50,
  parameter int DINO_X     = 200,
  parameter int GROUND_Y   = 515,
  parameter int SPAWN_X    = 783,
  parameter int OBS_GAP    = 320,
  parameter int LEFT_X     = 144,
  parameter int JUMP_V     = 20,
  parameter int GRAVITY    = 1,
  parameter int SPEED0     = 4,
  parameter int SPEED_MAX  = 12,
  parameter int SPEED_STEP = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               up,
  input  logic               bright,
  input  logic [9:0]         hCount,
  input  logic [9:0]         vCount,
  output logic [11:0]        rgb,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state
`ifdef HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);
  localparam logic [1:0] INI = 2'd0, PLAY = 2'd1, DONE = 2'd2;
  localparam logic [10:0] GY = 11'(GROUND_Y);
  localparam logic [10:0] LX = 11'(LEFT_X);
  localparam logic [10:0] SX = 11'(SPAWN_X);
  localparam logic [10:0] WRAP = 11'(NUM_OBS * OBS_GAP);
  localparam logic [10:0] SZ = 11'(SIZE);
  localparam logic [10:0] DX = 11'(DINO_X);
  localparam logic [7:0] SMAX = 8'(SPEED_MAX);
  localparam logic [SCORE_W-1:0] STEP = SCORE_W'(SPEED_STEP);

  logic up_q, airborne, jump_req;
  logic [10:0] ypos;
  logic signed [7:0] vel;
  logic [7:0] speed;
  logic [10:0] obs_x [NUM_OBS];

  logic up_rise, tick, restart, do_jump, land, hit, inc, spd_up, dino_px;
  logic signed [7:0] nv, new_vel;
  logic [10:0] fall_y, new_y, h, v;
  logic [10:0] new_x [NUM_OBS];
  logic [NUM_OBS-1:0] pass, obs_hit, obs_on;
  logic [SCORE_W-1:0] sc_inc;
  logic [11:0] pix;

  always_comb begin
    up_rise = up & ~up_q;
    tick = frame_tick && state == PLAY;
    restart = state == DONE && up_rise;
    do_jump = jump_req && !airborne;
    // gravity is applied before the position step, so the apex lands GROUND_Y-sum(JUMP_V..1)
    nv = vel - 8'(GRAVITY);
    fall_y = ypos - {{3{nv[7]}}, nv};
    land = fall_y >= GY;
    new_y = do_jump ? GY - 11'(JUMP_V) : !airborne ? ypos : land ? GY : fall_y;
    new_vel = do_jump ? 8'(JUMP_V) : (!airborne || land) ? 8'sd0 : nv;
    h = {1'b0, hCount};
    v = {1'b0, vCount};
    for (int i = 0; i < NUM_OBS; i++) begin
      pass[i] = obs_x[i] - 11'(speed) < LX;
      new_x[i] = obs_x[i] - 11'(speed) + (pass[i] ? WRAP : 11'd0);
      obs_hit[i] = new_x[i] < DX + SZ && {1'b0, new_x[i]} + 12'(SIZE) > 12'(DINO_X);
      obs_on[i] = obs_x[i] <= SX && h >= obs_x[i] && {1'b0, h} < {1'b0, obs_x[i]} + 12'(SIZE)
                  && v >= GY - SZ && v < GY;
    end
    hit = |obs_hit && new_y > GY - SZ && {1'b0, new_y} < 12'(GROUND_Y + SIZE);
    sc_inc = score + 1'b1;
    inc = |pass && !hit && !(&score);
    spd_up = inc && sc_inc % STEP == '0 && speed < SMAX;
    dino_px = h >= DX && h < DX + SZ && v >= ypos - SZ && v < ypos;
    pix = !bright ? 12'h000 : dino_px ? (state == DONE ? 12'hF00 : 12'h0F0) :
          |obs_on ? 12'hA50 : v == GY ? 12'h888 : 12'hFFF;
  end

  always_ff @(posedge clk) begin
    up_q <= rst ? 1'b0 : up;
    if (rst || restart) begin
      state <= INI;
      score <= '0;
      ypos <= GY;
      vel <= '0;
      airborne <= 1'b0;
      jump_req <= 1'b0;
      speed <= 8'(SPEED0);
      rgb <= '0;
      for (int i = 0; i < NUM_OBS; i++) obs_x[i] <= 11'(SPAWN_X + i * OBS_GAP);
    end else begin
      rgb <= pix;
      if (state == INI && up_rise) state <= PLAY;
      if (state == PLAY && up_rise && !airborne) jump_req <= 1'b1;
      if (tick) begin
        ypos <= new_y;
        vel <= new_vel;
        airborne <= do_jump || (airborne && !land);
        if (do_jump) jump_req <= 1'b0;
        for (int i = 0; i < NUM_OBS; i++) obs_x[i] <= new_x[i];
        if (inc) score <= sc_inc;
        if (spd_up) speed <= speed + 1'b1;
        if (hit) state <= DONE;
      end
    end
  end

`ifdef HISCORE_EN
  always_ff @(posedge clk) begin
    if (rst) hiscore <= '0;
    else if (tick && hit && score > hiscore) hiscore <= score;
  end
`endif
endmodule

// File: tb/tb_dino_runner_core.sv
// tb_dino_runner_core: directed vectors plus multi-cycle game sequences for dino_runner_core
module tb_dino_runner_core;
  logic clk = 0, rst = 1, frame_tick = 0, up = 0, bright = 0;
  logic [9:0] hCount = 0, vCount = 0;
  logic [11:0] rgb;
  logic [15:0] score;
  logic [1:0] state;
  logic ft5 = 0, up5 = 0;
  logic [11:0] rgb5;
  logic [3:0] score5;
  logic [1:0] state5;
`ifdef HISCORE_EN
  logic [15:0] hiscore;
  logic [3:0] hiscore5;
`endif
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  dino_runner_core dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .up(up), .bright(bright),
    .hCount(hCount), .vCount(vCount), .rgb(rgb), .score(score), .state(state)
`ifdef HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  dino_runner_core #(.SCORE_W(4), .NUM_OBS(1)) u5 (
    .clk(clk), .rst(rst), .frame_tick(ft5), .up(up5), .bright(bright),
    .hCount(hCount), .vCount(vCount), .rgb(rgb5), .score(score5), .state(state5)
`ifdef HISCORE_EN
    , .hiscore(hiscore5)
`endif
  );

  typedef struct {
    logic       b;
    logic [9:0] h;
    logic [9:0] v;
    logic [11:0] exp;
  } pix_t;
  pix_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1;
    step();
    frame_tick = 0;
    step();
  endtask

  task automatic press();
    up = 1;
    step();
    up = 0;
    step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic in_win(input logic [10:0] x);
    return x >= 260 && x <= 270;
  endfunction

`ifdef HISCORE_EN
  task automatic play(input int target);
    press();
    for (int f = 0; f < 2000 && state != 2; f++) begin
      if (score < target && !dut.airborne && !dut.jump_req &&
          (in_win(dut.obs_x[0]) || in_win(dut.obs_x[1]) || in_win(dut.obs_x[2])))
        press();
      frame();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int k, sp7, sp8;
    tbl[0]  = '{1'b0, 10'd220, 10'd490, 12'h000};
    tbl[1]  = '{1'b1, 10'd220, 10'd490, 12'h0F0};
    tbl[2]  = '{1'b1, 10'd200, 10'd465, 12'h0F0};
    tbl[3]  = '{1'b1, 10'd249, 10'd514, 12'h0F0};
    tbl[4]  = '{1'b1, 10'd250, 10'd490, 12'hFFF};
    tbl[5]  = '{1'b1, 10'd199, 10'd490, 12'hFFF};
    tbl[6]  = '{1'b1, 10'd220, 10'd464, 12'hFFF};
    tbl[7]  = '{1'b1, 10'd220, 10'd515, 12'h888};
    tbl[8]  = '{1'b1, 10'd800, 10'd490, 12'hA50};
    tbl[9]  = '{1'b1, 10'd783, 10'd465, 12'hA50};
    tbl[10] = '{1'b1, 10'd833, 10'd490, 12'hFFF};
    tbl[11] = '{1'b1, 10'd782, 10'd490, 12'hFFF};
    tbl[12] = '{1'b1, 10'd800, 10'd515, 12'h888};
    tbl[13] = '{1'b1, 10'd10,  10'd10,  12'hFFF};

    step();
    step();
    rst = 0;
    step();
    chk("reset_state", state, 0);
    chk("reset_score", score, 0);
    chk("reset_rgb", rgb, 0);
    chk("reset_ypos", dut.ypos, 515);

    for (int i = 0; i < 100; i++) frame();
    chk("ini_state", state, 0);
    chk("ini_score", score, 0);
    chk("ini_obs0", dut.obs_x[0], 783);

    for (int i = 0; i < 14; i++) begin
      bright = tbl[i].b;
      hCount = tbl[i].h;
      vCount = tbl[i].v;
      step();
      chk($sformatf("rgb_vec%0d", i), rgb, tbl[i].exp);
    end
    bright = 0;

    up = 1;
    step();
    chk("start_state", state, 1);
    up = 0;
    step();
    frame();
    chk("first_tick_obs0", dut.obs_x[0], 779);
    chk("first_tick_ypos", dut.ypos, 515);

    press();
    for (int t = 1; t <= 41; t++) begin
      if (t == 10) press();
      frame();
      if (t == 1) begin
        chk("jump_ypos1", dut.ypos, 495);
        chk("jump_vel1", dut.vel, 20);
      end
      if (t == 21) chk("apex_ypos", dut.ypos, 305);
      if (t == 40) chk("pre_land_ypos", dut.ypos, 495);
    end
    chk("land_ypos", dut.ypos, 515);
    chk("land_airborne", dut.airborne, 0);
    chk("air_press_ignored", dut.jump_req, 0);

    for (k = 0; k < 200 && state != 2; k++) frame();
    chk("hit_tick", 42 + k, 134);
    chk("done_state", state, 2);
    chk("done_score", score, 0);
    chk("done_obs0", dut.obs_x[0], 247);
    for (int i = 0; i < 5; i++) frame();
    chk("frozen_obs0", dut.obs_x[0], 247);
    chk("frozen_state", state, 2);
    bright = 1;
    hCount = 220;
    vCount = 490;
    step();
    chk("done_dino_rgb", rgb, 12'hF00);
    hCount = 260;
    step();
    chk("done_obs_rgb", rgb, 12'hA50);
    bright = 0;
    up = 1;
    step();
    chk("restart_state", state, 0);
    chk("restart_score", score, 0);
    chk("restart_obs0", dut.obs_x[0], 783);
    up = 0;
    step();

    press();
    press();
    for (int i = 0; i < 5; i++) frame();
    chk("midjump_airborne", dut.airborne, 1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_mid_state", state, 0);
    chk("rst_mid_ypos", dut.ypos, 515);
    chk("rst_mid_vel", dut.vel, 0);
    chk("rst_mid_airborne", dut.airborne, 0);
    chk("rst_mid_obs0", dut.obs_x[0], 783);

    sp7 = -1;
    sp8 = -1;
    up5 = 1;
    step();
    up5 = 0;
    step();
    for (int f = 0; f < 1900; f++) begin
      logic [3:0] prev;
      if (!u5.airborne && !u5.jump_req && in_win(u5.obs_x[0])) begin
        up5 = 1;
        step();
        up5 = 0;
        step();
      end
      prev = score5;
      ft5 = 1;
      step();
      ft5 = 0;
      step();
      if (prev == 6 && score5 == 7) sp7 = int'(u5.speed);
      if (prev == 7 && score5 == 8) sp8 = int'(u5.speed);
    end
    chk("speed_at_7", sp7, 4);
    chk("speed_at_8", sp8, 5);
    chk("sat_score", score5, 15);
    chk("sat_state", state5, 1);
    chk("sat_speed", u5.speed, 5);

`ifdef HISCORE_EN
    play(3);
    chk("hs_game1_state", state, 2);
    chk("hs_game1_score", score, 3);
    chk("hs_after1", hiscore, 3);
    press();
    chk("hs_restart_state", state, 0);
    play(1);
    chk("hs_game2_score", score, 1);
    chk("hs_after2", hiscore, 3);
    rst = 1;
    step();
    rst = 0;
    chk("hs_rst", hiscore, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
